pe_mvm_sequencer: RTL and testbench

- Drives the 8-input/4-output 16-bit PE: assembles a serial stream of Q0.15 input words into the PE DATA vector and fetches the matching weight tile from weight memory.
- Fires the PE clock enable exactly once when the transfer-function output is valid.
- Serialises the 4 Q0.15 neuron outputs back onto a valid/ready stream.
- Sits between the reservoir state buffer and the PE array, one instance per PE.

---
 rtl/pe_mvm_sequencer.sv | 153 +++++++++++++++
 tb/tb_pe_mvm_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mvm_sequencer.sv
// Sequencer between the reservoir state buffer and one 8-in/4-out PE.
// It gathers a serial input vector, fetches its weight tile, fires the PE once and streams out the results.
module pe_mvm_sequencer #(
    parameter int WORD_LEN = 16,
    parameter int NEU_IN   = 8,
    parameter int NEU_OUT  = 4,
    parameter int ADDR_W   = 6,
    parameter int PE_LAT   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WORD_LEN-1:0]                 in_data,
    input  logic [ADDR_W-1:0]                   tile,
    output logic                                w_en,
    output logic [ADDR_W-1:0]                   w_addr,
    input  logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]  w_rdata,
    output logic [WORD_LEN*NEU_IN-1:0]          pe_data,
    output logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]  pe_weight,
    output logic                                pe_ce,
    input  logic [WORD_LEN*NEU_OUT-1:0]         pe_q,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WORD_LEN-1:0]                 out_data,
    output logic                                out_last,
    output logic                                busy,
    output logic [15:0]                         vec_count
);

    localparam int IN_W   = (NEU_IN  > 1) ? $clog2(NEU_IN)  : 1;
    localparam int OUT_W  = (NEU_OUT > 1) ? $clog2(NEU_OUT) : 1;
    localparam int WAIT_W = (PE_LAT  > 1) ? $clog2(PE_LAT)  : 1;

    localparam logic [IN_W-1:0]   IN_LAST   = IN_W'(NEU_IN - 1);
    localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(NEU_OUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PE_LAT - 1);

    typedef enum logic [2:0] {
        FILL,
        FETCH,
        WAIT,
        FIRE,
        DRAIN
    } state_t;

    state_t                             state;
    logic [IN_W-1:0]                    in_cnt;
    logic [OUT_W-1:0]                   out_cnt;
    logic [WAIT_W-1:0]                  wait_cnt;
    logic [15:0]                        vec_cnt;
    logic [NEU_IN-1:0][WORD_LEN-1:0]    data_words;
    logic [NEU_OUT-1:0][WORD_LEN-1:0]   q_words;

    assign pe_data   = data_words;
    assign pe_weight = w_rdata;
    assign q_words   = pe_q;
    assign vec_count = vec_cnt;

    // The PE holds Q for the whole drain, so the output word is a plain mux on out_cnt.
    assign out_data  = q_words[out_cnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            in_cnt     <= '0;
            out_cnt    <= '0;
            wait_cnt   <= '0;
            vec_cnt    <= '0;
            data_words <= '0;
            w_addr     <= '0;
            w_en       <= 1'b0;
            pe_ce      <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid && in_ready) begin
                        data_words[in_cnt] <= in_data;
                        if (in_cnt == '0) begin
                            w_addr <= tile;
                        end
                        if (in_cnt == IN_LAST) begin
                            in_cnt   <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            w_en     <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end

                FETCH: begin
                    w_en     <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end

                // Weight tile lands the first WAIT cycle; count out the PE transfer latency.
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        pe_ce    <= 1'b1;
                        state    <= FIRE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                FIRE: begin
                    pe_ce     <= 1'b0;
                    out_valid <= 1'b1;
                    out_cnt   <= '0;
                    out_last  <= (OUT_LAST == '0);
                    state     <= DRAIN;
                end

                DRAIN: begin
                    if (out_ready) begin
                        if (out_cnt == OUT_LAST) begin
                            out_cnt   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            vec_cnt   <= vec_cnt + 16'd1;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= FILL;
                        end else begin
                            out_cnt  <= out_cnt + 1'b1;
                            out_last <= ((out_cnt + 1'b1) == OUT_LAST);
                        end
                    end
                end

                default: begin
                    state     <= FILL;
                    w_en      <= 1'b0;
                    pe_ce     <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mvm_sequencer.sv
// Directed bench for pe_mvm_sequencer with a behavioural weight memory and PE.
module tb_pe_mvm_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic [5:0]    tile;
    logic          w_en;
    logic [5:0]    w_addr;
    logic [511:0]  w_rdata = '0;
    logic [127:0]  pe_data;
    logic [511:0]  pe_weight;
    logic          pe_ce;
    logic [63:0]   pe_q = '0;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          out_last;
    logic          busy;
    logic [15:0]   vec_count;

    pe_mvm_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tile      (tile),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_rdata   (w_rdata),
        .pe_data   (pe_data),
        .pe_weight (pe_weight),
        .pe_ce     (pe_ce),
        .pe_q      (pe_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int wen_cnt = 0, wen_cyc = -1, ce_cnt = 0, ce_cyc = -1, ov_cnt = 0, ov_rise = -1;
    logic ov_prev = 1'b0;
    logic [127:0] ce_data;
    logic [511:0] ce_weight;
    logic [5:0]   wen_q[$];
    logic [16:0]  outq[$];

    function automatic logic [15:0] wword(input logic [5:0] a, input int j);
        return {a, 2'b00, 8'(j)};
    endfunction

    function automatic logic [511:0] wtile(input logic [5:0] a);
        logic [511:0] t;
        for (int j = 0; j < 32; j++) t[j*16 +: 16] = wword(a, j);
        return t;
    endfunction

    function automatic logic [15:0] din(input logic [15:0] start, input logic [15:0] step, input int i);
        return start + step * 16'(i);
    endfunction

    function automatic logic [127:0] exp_data(input logic [15:0] start, input logic [15:0] step);
        logic [127:0] d;
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = din(start, step, i);
        return d;
    endfunction

    // Reference PE response: q_k = x_k ^ x_(k+4) ^ first weight of row k.
    function automatic logic [15:0] exp_q(input int k, input logic [15:0] start, input logic [15:0] step,
                                          input logic [5:0] t);
        return din(start, step, k) ^ din(start, step, k + 4) ^ wword(t, k * 8);
    endfunction

    // Registered weight memory and PE models
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_en) w_rdata <= wtile(w_addr);
        if (pe_ce) begin
            for (int k = 0; k < 4; k++)
                pe_q[k*16 +: 16] <= pe_data[k*16 +: 16] ^ pe_data[(k+4)*16 +: 16] ^ pe_weight[k*8*16 +: 16];
        end
    end

    always @(negedge clk) begin
        if (w_en) begin
            wen_cnt++;
            wen_cyc = cyc;
            wen_q.push_back(w_addr);
        end
        if (pe_ce) begin
            ce_cnt++;
            ce_cyc    = cyc;
            ce_data   = pe_data;
            ce_weight = pe_weight;
        end
        if (out_valid && !ov_prev) ov_rise = cyc;
        if (out_valid) ov_cnt++;
        ov_prev = out_valid;
        if (out_valid && out_ready) outq.push_back({out_last, out_data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic [5:0] t, output int hs);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        tile     = t;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_handshake_timeout", 64'(in_ready), 64'(1));
        hs = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [15:0] start, input logic [15:0] step, input logic [5:0] t,
                            input int gap_at, input int gap_len, output int first, output int last);
        int hs;
        int wen0;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                wen0 = wen_cnt;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    chk("gap_in_ready", 64'(in_ready), 64'(1));
                    chk("gap_in_cnt", 64'(dut.in_cnt), 64'(gap_at));
                    chk("gap_no_w_en", 64'(wen_cnt - wen0), 64'(0));
                    @(posedge clk);
                    #1;
                end
            end
            send_word(din(start, step, i), t, hs);
            if (i == 0) first = hs;
            last = hs;
        end
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (outq.size() < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("out_words_arrived", 64'(outq.size() >= n), 64'(1));
        @(negedge clk);
    endtask

    task automatic check_out(input int base, input logic [15:0] start, input logic [15:0] step,
                             input logic [5:0] t);
        for (int k = 0; k < 4; k++) begin
            if (base + k < outq.size())
                chk($sformatf("out_word%0d", base + k), 64'(outq[base + k]),
                    64'({(k == 3), exp_q(k, start, step, t)}));
            else
                chk($sformatf("out_word%0d_missing", base + k), 64'(outq.size()), 64'(base + k + 1));
        end
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int f0, t0, f1, t1, ce0, ov0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        tile      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_strobes", 64'({w_en, pe_ce, out_valid, out_last}), 64'(0));
        chk("rst_vec_count", 64'(vec_count), 64'(0));
        chk("rst_w_addr", 64'(w_addr), 64'(0));
        chk("rst_pe_data", 64'(pe_data == '0), 64'(1));
        @(posedge clk);
        #1;

        // Abort in WAIT
        ce0 = ce_cnt;
        ov0 = ov_cnt;
        outq.delete();
        send_vec(16'h0A00, 16'h0010, 6'd9, -1, 0, f0, t0);
        to_cycle(t0 + 2);
        chk("abort_in_wait_state", 64'(busy && !in_ready && !w_en), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_w_addr", 64'(w_addr), 64'(0));
        repeat (12) @(negedge clk);
        chk("abort_no_pe_ce", 64'(ce_cnt - ce0), 64'(0));
        chk("abort_no_out_valid", 64'(ov_cnt - ov0), 64'(0));
        chk("abort_no_out_words", 64'(outq.size()), 64'(0));
        chk("abort_vec_count", 64'(vec_count), 64'(0));
        @(posedge clk);
        #1;

        // Basic vector, tile 5
        wen_q.delete();
        outq.delete();
        ce0 = ce_cnt;
        send_vec(16'h0100, 16'h0100, 6'd5, -1, 0, f0, t0);
        wait_out(4);
        chk("v1_w_en_once", 64'(wen_q.size()), 64'(1));
        if (wen_q.size() > 0) chk("v1_w_addr", 64'(wen_q[0]), 64'(5));
        chk("v1_w_en_cycle", 64'(wen_cyc), 64'(t0 + 1));
        chk("v1_pe_ce_once", 64'(ce_cnt - ce0), 64'(1));
        chk("v1_pe_ce_cycle", 64'(ce_cyc), 64'(wen_cyc + 3));
        chk("v1_pe_data", 64'(ce_data == exp_data(16'h0100, 16'h0100)), 64'(1));
        chk("v1_pe_data_word0", 64'(ce_data[15:0]), 64'(16'h0100));
        chk("v1_pe_weight", 64'(ce_weight == wtile(6'd5)), 64'(1));
        chk("v1_first_out_valid", 64'(ov_rise), 64'(t0 + 5));
        chk("v1_out_word0_hand", 64'(outq.size() > 0 ? outq[0] : 17'h0), 64'(17'h01000));
        check_out(0, 16'h0100, 16'h0100, 6'd5);
        chk("v1_vec_count", 64'(vec_count), 64'(1));
        chk("v1_idle_in_ready", 64'(in_ready), 64'(1));

        // Input stall after word 4
        wen_q.delete();
        outq.delete();
        ce0 = ce_cnt;
        @(posedge clk);
        #1;
        send_vec(16'h0100, 16'h0100, 6'd5, 4, 3, f0, t0);
        wait_out(4);
        chk("v2_w_en_once", 64'(wen_q.size()), 64'(1));
        chk("v2_w_en_cycle", 64'(wen_cyc), 64'(t0 + 1));
        chk("v2_pe_ce_cycle", 64'(ce_cyc), 64'(t0 + 4));
        chk("v2_pe_ce_once", 64'(ce_cnt - ce0), 64'(1));
        chk("v2_pe_data", 64'(ce_data == exp_data(16'h0100, 16'h0100)), 64'(1));
        check_out(0, 16'h0100, 16'h0100, 6'd5);
        chk("v2_vec_count", 64'(vec_count), 64'(2));

        // Output backpressure on word 2
        outq.delete();
        ce0 = ce_cnt;
        @(posedge clk);
        #1;
        send_vec(16'h7F00, 16'hF001, 6'd12, -1, 0, f0, t0);
        to_cycle(t0 + 7);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_out_data", 64'(out_data), 64'(exp_q(2, 16'h7F00, 16'hF001, 6'd12)));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_pe_ce", 64'(pe_ce), 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_out(4);
        check_out(0, 16'h7F00, 16'hF001, 6'd12);
        chk("bp_pe_ce_once", 64'(ce_cnt - ce0), 64'(1));
        chk("bp_vec_count", 64'(vec_count), 64'(3));

        // Back-to-back vectors, tiles 3 then 7
        wen_q.delete();
        outq.delete();
        ce0 = ce_cnt;
        @(posedge clk);
        #1;
        send_vec(16'h1000, 16'h0011, 6'd3, -1, 0, f0, t0);
        send_vec(16'h2000, 16'h0101, 6'd7, -1, 0, f1, t1);
        wait_out(8);
        chk("b2b_w_en_count", 64'(wen_q.size()), 64'(2));
        if (wen_q.size() > 1) begin
            chk("b2b_w_addr_a", 64'(wen_q[0]), 64'(3));
            chk("b2b_w_addr_b", 64'(wen_q[1]), 64'(7));
        end
        chk("b2b_pe_ce_count", 64'(ce_cnt - ce0), 64'(2));
        chk("b2b_restart_gap", 64'(f1 - t0), 64'(9));
        check_out(0, 16'h1000, 16'h0011, 6'd3);
        check_out(4, 16'h2000, 16'h0101, 6'd7);
        chk("b2b_vec_count", 64'(vec_count), 64'(5));

        // vec_count wrap
        force dut.vec_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.vec_cnt;
        @(negedge clk);
        chk("wrap_preload", 64'(vec_count), 64'(16'hFFFF));
        outq.delete();
        @(posedge clk);
        #1;
        send_vec(16'h8000, 16'h1234, 6'd63, -1, 0, f0, t0);
        wait_out(4);
        check_out(0, 16'h8000, 16'h1234, 6'd63);
        chk("wrap_vec_count", 64'(vec_count), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
